// File: rtl/pid_sched_pkg.sv
// Shared types and constants for the time-shared PID scheduler.
// Holds the sequencer states, coefficient addresses and clamp limits.
package pid_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL_P,
        ST_MUL_I,
        ST_MUL_D,
        ST_ACC,
        ST_OUT
    } pid_state_e;

    localparam logic [1:0] ADDR_KP = 2'd0;
    localparam logic [1:0] ADDR_KI = 2'd1;
    localparam logic [1:0] ADDR_KD = 2'd2;

    localparam int UW_DEF = 15;

    function automatic longint sat_max(input int uw);
        return (longint'(1) <<< (uw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int uw);
        return -(longint'(1) <<< (uw - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(UW_DEF);
    localparam longint SAT_MIN = sat_min(UW_DEF);

endpackage

// File: rtl/pid_rr_arbiter.sv
// Round-robin request arbiter, purely combinational.
// Grants the lowest requesting index at or after the pointer.
module pid_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int            c;
    logic [IW-1:0] c_idx;

    // Scan from the pointer, wrapping once, and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        c_idx = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            c_idx = IW'(c);
            if (!any_o && req_i[c_idx]) begin
                any_o        = 1'b1;
                gnt_o[c_idx] = 1'b1;
                idx_o        = c_idx;
            end
        end
    end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Multi-channel incremental PID sharing one multiplier.
// Round-robin grants, per-channel history, saturated output.
module pid_channel_scheduler
    import pid_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int EW   = 12,
    parameter int CW   = 12,
    parameter int UW   = 15,
    parameter int FRAC = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*EW-1:0]        err_in,
    output logic [N_CH-1:0]           ack,
    input  logic [N_CH-1:0]           ch_clr,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [CW-1:0]             cfg_data,
    output logic                      out_valid,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic [UW-1:0]             out_uk,
    output logic                      busy
);

    localparam int IW = $clog2(N_CH);
    localparam int SW = EW + CW + 4;
    localparam int DW = EW + 2;
    localparam int PW = DW + CW;

    localparam logic signed [SW-1:0] UMAX = SW'(sat_max(UW));
    localparam logic signed [SW-1:0] UMIN = SW'(sat_min(UW));

    pid_state_e state_q, state_d;

    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   g_q;
    logic [N_CH-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    logic signed [CW-1:0] kp_q, ki_q, kd_q;
    logic signed [CW-1:0] kps_q, kis_q, kds_q;

    logic signed [EW-1:0] e1_q [N_CH];
    logic signed [EW-1:0] e2_q [N_CH];
    logic signed [UW-1:0] u1_q [N_CH];

    logic signed [EW-1:0] e0_q, e1s_q, e2s_q;
    logic signed [UW-1:0] u1s_q;
    logic signed [EW-1:0] err_sel;

    logic signed [DW-1:0] e0x, e1x, e2x;
    logic signed [DW-1:0] op_a;
    logic signed [CW-1:0] op_k;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum_q, sum_d;
    logic signed [SW-1:0] d_uk, uk_full;
    logic signed [UW-1:0] uk_sat;

    logic [N_CH-1:0]      ack_q;
    logic                 out_valid_q;
    logic [IW-1:0]        out_ch_q;
    logic signed [UW-1:0] out_uk_q;

    pid_rr_arbiter #(
        .N  (N_CH),
        .IW (IW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: wait for a grant, then walk the fixed schedule.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (gnt_any) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_MUL_P;
            ST_MUL_P: state_d = ST_MUL_I;
            ST_MUL_I: state_d = ST_MUL_D;
            ST_MUL_D: state_d = ST_ACC;
            ST_ACC:   state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Coefficient registers written by the config port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kp_q <= '0;
            ki_q <= '0;
            kd_q <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_KP: kp_q <= cfg_data;
                ADDR_KI: ki_q <= cfg_data;
                ADDR_KD: kd_q <= cfg_data;
                default: ;
            endcase
        end
    end

    // Latch the granted channel and advance the pointer past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q   <= '0;
            ptr_q <= '0;
        end else begin
            if (state_q == ST_IDLE && gnt_any)
                g_q <= gnt_idx;
            if (state_q == ST_LOAD)
                ptr_q <= (g_q == IW'(N_CH - 1)) ? '0 : g_q + 1'b1;
        end
    end

    // Select the granted channel's error sample.
    always_comb begin
        err_sel = '0;
        for (int i = 0; i < N_CH; i++)
            if (g_q == IW'(i)) err_sel = err_in[i*EW +: EW];
    end

    // Snapshot operands so later clears/config cannot disturb the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1s_q <= '0;
            e2s_q <= '0;
            u1s_q <= '0;
            kps_q <= '0;
            kis_q <= '0;
            kds_q <= '0;
        end else if (state_q == ST_LOAD) begin
            e0_q  <= err_sel;
            e1s_q <= e1_q[g_q];
            e2s_q <= e2_q[g_q];
            u1s_q <= u1_q[g_q];
            kps_q <= kp_q;
            kis_q <= ki_q;
            kds_q <= kd_q;
        end
    end

    assign e0x = DW'(e0_q);
    assign e1x = DW'(e1s_q);
    assign e2x = DW'(e2s_q);

    // Operand mux for the single shared multiplier.
    always_comb begin
        op_a = '0;
        op_k = '0;
        unique case (state_q)
            ST_MUL_P: begin
                op_a = e0x - e1x;
                op_k = kps_q;
            end
            ST_MUL_I: begin
                op_a = e0x;
                op_k = kis_q;
            end
            ST_MUL_D: begin
                op_a = e0x - (e1x <<< 1) + e2x;
                op_k = kds_q;
            end
            default: ;
        endcase
    end

    assign prod = PW'(op_a) * PW'(op_k);

    // Product sum: first term overwrites, later terms accumulate.
    always_comb begin
        sum_d = sum_q;
        unique case (state_q)
            ST_MUL_P: sum_d = SW'(prod);
            ST_MUL_I: sum_d = sum_q + SW'(prod);
            ST_MUL_D: sum_d = sum_q + SW'(prod);
            default:  ;
        endcase
    end

    // Product sum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    // Scale, add previous output at full width, then clamp.
    always_comb begin
        d_uk    = sum_q >>> FRAC;
        uk_full = SW'(u1s_q) + d_uk;
        if (uk_full > UMAX)      uk_sat = UMAX[UW-1:0];
        else if (uk_full < UMIN) uk_sat = UMIN[UW-1:0];
        else                     uk_sat = uk_full[UW-1:0];
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_uk_q    <= '0;
        end else begin
            ack_q       <= (state_q == ST_IDLE && gnt_any) ? gnt_oh : '0;
            out_valid_q <= (state_q == ST_ACC);
            if (state_q == ST_ACC) begin
                out_ch_q <= g_q;
                out_uk_q <= uk_sat;
            end
        end
    end

    // History file: write-back wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                e1_q[i] <= '0;
                e2_q[i] <= '0;
                u1_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (state_q == ST_OUT && g_q == IW'(i)) begin
                    e2_q[i] <= e1_q[i];
                    e1_q[i] <= e0_q;
                    u1_q[i] <= out_uk_q;
                end else if (ch_clr[i]) begin
                    e1_q[i] <= '0;
                    e2_q[i] <= '0;
                    u1_q[i] <= '0;
                end
            end
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_uk    = out_uk_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Self-checking bench for pid_channel_scheduler.
// Directed scenarios plus random traffic against an arithmetic model.
module tb_pid_channel_scheduler;

    localparam int N  = 4;
    localparam int EW = 12;
    localparam int CW = 12;
    localparam int UW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*EW-1:0] err_in;
    logic [N-1:0]  ack;
    logic [N-1:0]  ch_clr;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          out_valid;
    logic [1:0]    out_ch;
    logic [UW-1:0] out_uk;
    logic          busy;

    pid_channel_scheduler #(
        .N_CH (N),
        .EW   (EW),
        .CW   (CW),
        .UW   (UW),
        .FRAC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .err_in    (err_in),
        .ack       (ack),
        .ch_clr    (ch_clr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_uk    (out_uk),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int m_kp, m_ki, m_kd, m_ptr;
    int m_e1 [N];
    int m_e2 [N];
    int m_u1 [N];
    int m_err [N];

    int x_ch, x_uk, x_e0, t_ack, last_uk;

    task automatic chk(input string tag, input int got,
                       input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int sat(input int v);
        if (v > 16383)  return 16383;
        if (v < -16384) return -16384;
        return v;
    endfunction

    function automatic int model_uk(input int ch, input int e0);
        int s;
        s = m_kp * (e0 - m_e1[ch]) + m_ki * e0
          + m_kd * (e0 - 2 * m_e1[ch] + m_e2[ch]);
        return sat(m_u1[ch] + (s >>> 8));
    endfunction

    function automatic int model_grant(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_kp = 0; m_ki = 0; m_kd = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_e1[i] = 0; m_e2[i] = 0; m_u1[i] = 0;
        end
    endtask

    function automatic int rnd_s12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic set_err(input int ch, input int e);
        m_err[ch] = e;
        err_in[ch*EW +: EW] = e[EW-1:0];
    endtask

    task automatic cfg(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = addr[1:0];
        cfg_data = val[CW-1:0];
        if (addr == 0) m_kp = val;
        if (addr == 1) m_ki = val;
        if (addr == 2) m_kd = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic clr(input logic [N-1:0] m);
        ch_clr = m;
        for (int i = 0; i < N; i++)
            if (m[i]) begin
                m_e1[i] = 0; m_e2[i] = 0; m_u1[i] = 0;
            end
        tick();
        ch_clr = '0;
    endtask

    task automatic await_ack(input bit rearm);
        int n, g;
        n = 0;
        while (ack === '0 && n < 30) begin
            tick();
            n++;
        end
        if (ack === '0) begin
            chk("ack_timeout", 0, 1);
            return;
        end
        g = model_grant(req);
        if (g < 0) g = 0;
        chk("grant", int'(ack), 1 << g);
        chk("busy_on", int'(busy), 1);
        x_ch  = g;
        x_e0  = m_err[g];
        x_uk  = model_uk(g, x_e0);
        t_ack = cyc;
        m_ptr = (g + 1) % N;
        req[g] = 1'b0;
        tick();
        chk("ack_pulse", int'(ack), 0);
        if (rearm) begin
            set_err(g, rnd_s12());
            req[g] = 1'b1;
        end
    endtask

    task automatic await_out(input bit clr_same);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            chk("out_timeout", 0, 1);
            return;
        end
        chk("latency", cyc - t_ack, 5);
        chk("out_ch", int'(out_ch), x_ch);
        chk("out_uk", int'($signed(out_uk)), x_uk);
        last_uk = int'($signed(out_uk));
        m_e2[x_ch] = m_e1[x_ch];
        m_e1[x_ch] = x_e0;
        m_u1[x_ch] = x_uk;
        if (clr_same) begin
            ch_clr = '1;
            for (int i = 0; i < N; i++)
                if (i != x_ch) begin
                    m_e1[i] = 0; m_e2[i] = 0; m_u1[i] = 0;
                end
        end
        tick();
        ch_clr = '0;
        chk("ov_pulse", int'(out_valid), 0);
    endtask

    task automatic sample(input int ch, input int e);
        set_err(ch, e);
        req[ch] = 1'b1;
        await_ack(1'b0);
        await_out(1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [N-1:0] m;
        rst_n    = 1'b0;
        req      = '0;
        err_in   = '0;
        ch_clr   = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        model_reset();
        for (int i = 0; i < N; i++) m_err[i] = 0;
        repeat (3) tick();
        chk("rst_ack", int'(ack), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_ch", int'(out_ch), 0);
        chk("rst_uk", int'(out_uk), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Proportional only: repeated error gives zero increment.
        cfg(0, 256);
        sample(0, 100);
        chk("kp_first", last_uk, 100);
        sample(0, 100);
        chk("kp_second", last_uk, 100);

        // Integral only: ramps by 50 per sample.
        cfg(0, 0);
        cfg(1, 128);
        for (int i = 0; i < 4; i++) begin
            sample(1, 100);
            chk("ki_ramp", last_uk, 50 * (i + 1));
        end

        // Round-robin with all channels requesting.
        do_reset();
        cfg(0, 100);
        cfg(1, 64);
        cfg(2, 30);
        for (int i = 0; i < N; i++) set_err(i, rnd_s12());
        req = '1;
        for (int k = 0; k < 5; k++) begin
            await_ack(1'b1);
            chk("rr_order", x_ch, k % N);
            await_out(1'b0);
        end
        req = '0;

        // Saturation and recovery without windup.
        cfg(0, 0);
        cfg(2, 0);
        cfg(1, 2047);
        clr(4'b0100);
        sample(2, 2047);
        chk("sat_1", last_uk, 16368);
        sample(2, 2047);
        chk("sat_2", last_uk, 16383);
        sample(2, 2047);
        chk("sat_3", last_uk, 16383);
        sample(2, -2047);
        chk("no_windup", last_uk, 14);

        // Config write while a result is in flight.
        cfg(1, 0);
        cfg(0, 256);
        clr(4'b0100);
        set_err(2, 40);
        req[2] = 1'b1;
        await_ack(1'b0);
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 12'd512;
        m_kp     = 512;
        tick();
        cfg_we = 1'b0;
        await_out(1'b0);
        chk("cfg_old", last_uk, 40);
        sample(2, 60);
        chk("cfg_new", last_uk, 80);

        // Reset in the middle of a computation.
        set_err(1, 77);
        req[1] = 1'b1;
        await_ack(1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("rst_abort", seen, 0);
        chk("rst2_uk", int'(out_uk), 0);
        chk("rst2_ch", int'(out_ch), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_ack", int'(ack), 0);
        cfg(0, 256);
        cfg(1, 128);
        sample(1, 100);
        chk("rst_hist", last_uk, 150);

        // Clear in IDLE restarts the channel history.
        sample(3, 100);
        chk("c3_first", last_uk, 150);
        sample(3, 100);
        chk("c3_second", last_uk, 200);
        clr(4'b1000);
        sample(3, 100);
        chk("c3_cleared", last_uk, 150);

        // Clear coinciding with write-back, then clear early in flight.
        set_err(0, 30);
        req[0] = 1'b1;
        await_ack(1'b0);
        await_out(1'b1);
        sample(0, 30);
        set_err(0, 50);
        req[0] = 1'b1;
        await_ack(1'b0);
        clr(4'b0001);
        await_out(1'b0);
        sample(0, 20);

        // Random traffic, coefficients and clears.
        for (int a = 0; a < 3; a++) cfg(a, rnd_s12());
        for (int it = 0; it < 60; it++) begin
            m = $urandom_range(1, 15);
            for (int i = 0; i < N; i++)
                if (m[i] && !req[i]) begin
                    set_err(i, rnd_s12());
                    req[i] = 1'b1;
                end
            await_ack($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                clr(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0)
                cfg($urandom_range(0, 3), rnd_s12());
            await_out($urandom_range(0, 5) == 0);
        end
        req = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
